// File: rtl/score_history_pkg.sv
// Shared constants for the reaction-timer result history.
package score_history_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int DIGITS_DEF = 6;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // "No best yet" marker for the default entry width. Larger than any valid BCD value.
    localparam int W_DEF = 4 * DIGITS_DEF;
    localparam logic [W_DEF-1:0] NO_BEST_DEF = {W_DEF{1'b1}};

endpackage

// File: rtl/score_history_if.sv
// Result-in / display-out bundle between the timer core, the history block and the BCD decoders.
interface score_history_if
    import score_history_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DIGITS = DIGITS_DEF
);
    localparam int W  = 4 * DIGITS;
    localparam int AW = $clog2(DEPTH);

    logic          res_valid;
    logic [W-1:0]  res_bcd;
    logic          step;
    logic          clear;
    logic [W-1:0]  disp_bcd;
    logic [AW-1:0] disp_idx;
    logic          disp_valid;
    logic [W-1:0]  best_bcd;
    logic          best_valid;
    logic          new_best;
    logic [AW:0]   count;
    logic          bad_in;

    modport master (
        output res_valid, res_bcd, step, clear,
        input  disp_bcd, disp_idx, disp_valid, best_bcd, best_valid, new_best, count, bad_in
    );

    modport slave (
        input  res_valid, res_bcd, step, clear,
        output disp_bcd, disp_idx, disp_valid, best_bcd, best_valid, new_best, count, bad_in
    );
endinterface

// File: rtl/score_history_regfile.sv
// DEPTH x W history storage: one synchronous write port, one combinational read port, no reset.
module history_regfile #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    // Storage write; contents are don't-care until written, the top masks reads while empty.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/score_history.sv
// Reaction-time history: circular capture buffer, best-time tracker and browse index.
module score_history
    import score_history_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    score_history_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] idx;
    logic [AW:0]   count;
    logic [W-1:0]  best;
    logic          best_valid;
    logic          new_best;
    logic          bad_in;
    logic          res_ok;
    logic          capture;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    // Every nibble must be a decimal digit before a result is accepted.
    always_comb begin
        res_ok = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (bus.res_bcd[4*d +: 4] > BCD_DIGIT_MAX)
                res_ok = 1'b0;
    end

    // CLEAR wins over a coincident result, which is then dropped.
    assign capture = bus.res_valid && res_ok && !bus.clear;

    // Newest entry sits just behind the write pointer; idx counts back in age.
    assign rd_addr = wr_ptr - AW'(1) - idx;

    history_regfile #(.DEPTH(DEPTH), .W(W)) u_regfile (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (bus.res_bcd),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Pointers, count, browse index and best value; CLEAR > capture > STEP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            idx        <= '0;
            count      <= '0;
            best       <= '1;
            best_valid <= 1'b0;
            new_best   <= 1'b0;
            bad_in     <= 1'b0;
        end else begin
            new_best <= 1'b0;
            bad_in   <= bus.res_valid && !res_ok;
            if (bus.clear) begin
                wr_ptr     <= '0;
                idx        <= '0;
                count      <= '0;
                best       <= '1;
                best_valid <= 1'b0;
            end else if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
                idx    <= '0;
                if (count != FULL)
                    count <= count + (AW+1)'(1);
                // Unsigned compare of packed BCD preserves decimal order; ties keep the old best.
                if (!best_valid || bus.res_bcd < best) begin
                    best       <= bus.res_bcd;
                    best_valid <= 1'b1;
                    new_best   <= 1'b1;
                end
            end else if (bus.step && count != '0) begin
                idx <= ({1'b0, idx} == count - (AW+1)'(1)) ? '0 : idx + AW'(1);
            end
        end
    end

    assign bus.disp_bcd   = (count != '0) ? rd_data : '0;
    assign bus.disp_idx   = idx;
    assign bus.disp_valid = (count != '0);
    assign bus.best_bcd   = best;
    assign bus.best_valid = best_valid;
    assign bus.new_best   = new_best;
    assign bus.count      = count;
    assign bus.bad_in     = bad_in;
endmodule

// File: tb/tb_score_history.sv
// Scoreboard bench for score_history (DEPTH=8, DIGITS=6).
module tb_score_history;
    localparam int DEPTH = 8;
    localparam int W = 24;

    typedef struct {
        logic [W-1:0] disp;
        logic [2:0]   idx;
        logic         dv;
        logic [W-1:0] best;
        logic         bv;
        logic         nb;
        logic [3:0]   cnt;
        logic         bad;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    exp_t q[$];

    // Reference state derived from the behavioural description.
    logic [W-1:0] hist [DEPTH];
    int m_wr, m_cnt, m_idx;
    logic [W-1:0] m_best;
    logic m_bv;

    score_history_if #(.DEPTH(DEPTH), .DIGITS(6)) bus ();
    score_history #(.DEPTH(DEPTH), .DIGITS(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_cnt = 0; m_idx = 0; m_best = '1; m_bv = 1'b0;
    endtask

    // Drive one cycle of stimulus, push the expected post-edge outputs, then compare them.
    task automatic cyc(input logic rv, input logic [W-1:0] b, input logic st, input logic cl);
        exp_t e, o;
        logic ok;
        bus.res_valid = rv; bus.res_bcd = b; bus.step = st; bus.clear = cl;
        ok = 1'b1;
        for (int d = 0; d < 6; d++) if (b[4*d +: 4] > 4'd9) ok = 1'b0;
        e.bad = rv && !ok;
        e.nb = 1'b0;
        if (cl) model_reset();
        else if (rv && ok) begin
            hist[m_wr] = b;
            m_wr = (m_wr + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
            m_idx = 0;
            if (!m_bv || b < m_best) begin m_best = b; m_bv = 1'b1; e.nb = 1'b1; end
        end else if (st && m_cnt > 0) m_idx = (m_idx == m_cnt - 1) ? 0 : m_idx + 1;
        e.disp = (m_cnt > 0) ? hist[(m_wr + 2*DEPTH - 1 - m_idx) % DEPTH] : '0;
        e.idx = 3'(m_idx); e.dv = (m_cnt > 0); e.best = m_best; e.bv = m_bv; e.cnt = 4'(m_cnt);
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0; bus.step = 1'b0; bus.clear = 1'b0;
        o = q.pop_front();
        chk("disp_bcd", 32'(bus.disp_bcd), 32'(o.disp));
        chk("disp_idx", 32'(bus.disp_idx), 32'(o.idx));
        chk("disp_valid", 32'(bus.disp_valid), 32'(o.dv));
        chk("best_bcd", 32'(bus.best_bcd), 32'(o.best));
        chk("best_valid", 32'(bus.best_valid), 32'(o.bv));
        chk("new_best", 32'(bus.new_best), 32'(o.nb));
        chk("count", 32'(bus.count), 32'(o.cnt));
        chk("bad_in", 32'(bus.bad_in), 32'(o.bad));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_disp"}, 32'(bus.disp_bcd), 32'h0);
        chk({tag, "_idx"}, 32'(bus.disp_idx), 32'h0);
        chk({tag, "_dv"}, 32'(bus.disp_valid), 32'h0);
        chk({tag, "_best"}, 32'(bus.best_bcd), 32'hffffff);
        chk({tag, "_bv"}, 32'(bus.best_valid), 32'h0);
        chk({tag, "_nb"}, 32'(bus.new_best), 32'h0);
        chk({tag, "_cnt"}, 32'(bus.count), 32'h0);
        chk({tag, "_bad"}, 32'(bus.bad_in), 32'h0);
    endtask

    initial begin
        bus.res_valid = 1'b0; bus.res_bcd = '0; bus.step = 1'b0; bus.clear = 1'b0;
        model_reset();
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;

        // First capture
        cyc(1'b1, 24'h000315, 1'b0, 1'b0);
        chk("first_disp", 32'(bus.disp_bcd), 32'h000315);
        chk("first_cnt", 32'(bus.count), 32'd1);
        chk("first_nb", 32'(bus.new_best), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Back-to-back captures, only the smaller one is a new best
        cyc(1'b1, 24'h000420, 1'b0, 1'b0);
        chk("b2b_nb420", 32'(bus.new_best), 32'd0);
        cyc(1'b1, 24'h000250, 1'b0, 1'b0);
        chk("b2b_nb250", 32'(bus.new_best), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("step1_disp", 32'(bus.disp_bcd), 32'h000420);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("step2_disp", 32'(bus.disp_bcd), 32'h000315);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("step_wrap", 32'(bus.disp_idx), 32'd0);

        // Overfill: oldest surviving entry is the second of nine
        for (int i = 1; i <= 9; i++) cyc(1'b1, 24'h000100 + 24'(i), 1'b0, 1'b0);
        chk("full_cnt", 32'(bus.count), 32'd8);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("oldest_idx", 32'(bus.disp_idx), 32'd7);
        chk("oldest_disp", 32'(bus.disp_bcd), 32'h000102);
        chk("full_best", 32'(bus.best_bcd), 32'h000101);

        // Non-BCD result, equal-to-best result, capture with step
        cyc(1'b1, 24'h00a123, 1'b0, 1'b0);
        chk("badin", 32'(bus.bad_in), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 24'h000101, 1'b1, 1'b0);
        chk("tie_nb", 32'(bus.new_best), 32'd0);
        chk("cap_step_idx", 32'(bus.disp_idx), 32'd0);

        // CLEAR beats a coincident result; STEP while empty does nothing
        cyc(1'b1, 24'h000050, 1'b0, 1'b1);
        chk("clr_cnt", 32'(bus.count), 32'd0);
        chk("clr_disp", 32'(bus.disp_bcd), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] b;
            b = 24'(($urandom_range(0, 9) << 8) | ($urandom_range(0, 9) << 4) | $urandom_range(0, 11));
            cyc(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between two captures
        cyc(1'b1, 24'h000888, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async");
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 24'h000777, 1'b0, 1'b0);
        chk("post_rst_idx", 32'(bus.disp_idx), 32'd0);
        chk("post_rst_cnt", 32'(bus.count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
